// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and helpers for the stream_mux_rr block.
//            MODE_FIXED / MODE_RR select encodings and a width helper that
//            never returns less than one bit.
// Revision : 1.0  initial release
// ============================================================================
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n items. A one-channel index still needs a real bit.
  function automatic int cw_of(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. The search starts one past
//            the last granted channel (ptr) and wraps modulo N. The first
//            requester found wins.
// Ports    : req   [N]  in   request vector
//            ptr   [CW] in   last granted channel index
//            grant [N]  out  one-hot grant, or all zeros
//            gidx  [CW] out  index of the granted channel (0 when none)
//            any        out  a grant was issued
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] gidx,
  output logic          any
);

  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = 0;
    // Offsets 1..N visit every channel once, ptr itself last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = CW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : N-channel valid/ready stream multiplexer with a registered
//            output stage. Fixed mode takes the channel from sel. RR mode
//            arbitrates fairly among the valid channels.
// Ports    : clk, rst              clock, synchronous active-high reset
//            mode                  0 fixed select, 1 round-robin
//            sel       [CW]        channel used in fixed mode
//            in_valid  [N]         per-channel valid
//            in_data   [N*WIDTH]   channel i at [i*WIDTH +: WIDTH]
//            in_ready  [N]         per-channel ready (combinational)
//            out_valid             output register holds a beat
//            out_data  [WIDTH]     held beat
//            out_chan  [CW]        source channel of the held beat
//            out_ready             consumer accepts the beat
// Revision : 1.0  initial release
// ============================================================================
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CW    = cw_of(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [CW-1:0]    sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_chan,
  input  logic             out_ready
);

  logic [CW-1:0]    r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_chan;

  logic [N-1:0]     w_rr_grant;
  logic [CW-1:0]    w_rr_gidx;
  logic             w_rr_any;

  logic [N-1:0]     w_grant;
  logic [CW-1:0]    w_gidx;
  logic             w_any;
  logic             w_load_en;
  logic             w_xfer;

  rr_arbiter #(
    .N  (N),
    .CW (CW)
  ) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_rr_grant),
    .gidx  (w_rr_gidx),
    .any   (w_rr_any)
  );

  // Grant source: arbiter in RR mode, sel in fixed mode. An out-of-range
  // sel yields no grant and a harmless index of zero.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    if (mode == MODE_RR) begin
      w_grant = w_rr_grant;
      w_gidx  = w_rr_gidx;
      w_any   = w_rr_any;
    end else if (int'(sel) < N) begin
      if (in_valid[sel]) begin
        w_grant[sel] = 1'b1;
        w_gidx       = sel;
        w_any        = 1'b1;
      end
    end
  end

  assign w_load_en = !r_valid || out_ready;
  assign in_ready  = (rst || !w_load_en) ? '0 : w_grant;
  // Grants only ever go to valid channels, so a live grant is a transfer.
  assign w_xfer    = !rst && w_load_en && w_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= CW'(N - 1);
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data[w_gidx*WIDTH +: WIDTH];
      r_chan  <= w_gidx;
      if (mode == MODE_RR) begin
        r_ptr <= w_gidx;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule : stream_mux_rr
`default_nettype wire
